// File: rtl/logic_sweep_ctrl.sv
// Exhaustive 16-vector sweep sequencer for a 4-input combinational block.
// Optional macro SWEEP_LOG_EN adds the observed_o truth-table capture port.
module logic_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED      = 16'h8000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        dut_out_i,
   output logic [3:0]  abcd_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [4:0]  err_count_o,
   output logic [3:0]  first_fail_o,
   output logic        first_fail_vld_o
`ifdef SWEEP_LOG_EN
   ,
   output logic [15:0] observed_o
`endif
);

   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE} state_e;

   state_e        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    abcd_q, abcd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [4:0]    err_q, err_d;
   logic [3:0]    ff_q, ff_d;
   logic          ffv_q, ffv_d;
   logic          mismatch;
`ifdef SWEEP_LOG_EN
   logic [15:0]   obs_q, obs_d;
`endif

   assign mismatch = (dut_out_i != EXPECTED[idx_q]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         abcd_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ff_q    <= '0;
         ffv_q   <= 1'b0;
`ifdef SWEEP_LOG_EN
         obs_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         abcd_q  <= abcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
`ifdef SWEEP_LOG_EN
         obs_q   <= obs_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_i) state_d = S_DRIVE;
         S_DRIVE:  state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = S_SAMPLE;
         S_SAMPLE: state_d = (idx_q == 4'hF) ? S_IDLE : S_DRIVE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      abcd_d = abcd_q;
      busy_d = busy_q;
      done_d = done_q;
      pass_d = pass_q;
      err_d  = err_q;
      ff_d   = ff_q;
      ffv_d  = ffv_q;
`ifdef SWEEP_LOG_EN
      obs_d  = obs_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               idx_d  = '0;
               err_d  = '0;
               ff_d   = '0;
               ffv_d  = 1'b0;
               done_d = 1'b0;
               pass_d = 1'b0;
               busy_d = 1'b1;
`ifdef SWEEP_LOG_EN
               obs_d  = '0;
`endif
            end
         end
         S_DRIVE: begin
            abcd_d = idx_q;
            cnt_d  = '0;
         end
         S_SETTLE: cnt_d = cnt_q + 1'b1;
         S_SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + 5'd1;
               if (!ffv_q) begin
                  ff_d  = idx_q;
                  ffv_d = 1'b1;
               end
            end
`ifdef SWEEP_LOG_EN
            obs_d[idx_q] = dut_out_i;
`endif
            // Verdict uses the count including this last sample.
            if (idx_q == 4'hF) begin
               done_d = 1'b1;
               pass_d = (err_d == 5'd0);
               busy_d = 1'b0;
               abcd_d = '0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   assign abcd_o           = abcd_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign err_count_o      = err_q;
   assign first_fail_o     = ff_q;
   assign first_fail_vld_o = ffv_q;
`ifdef SWEEP_LOG_EN
   assign observed_o       = obs_q;
`endif

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed bench for logic_sweep_ctrl: table of function-block behaviours plus
// start/reset corner sequences. Define SWEEP_LOG_EN to also check observed_o.
module tb_logic_sweep_ctrl;

   localparam int S = 2;
   localparam int P = S + 2;

   logic        clk = 1'b0;
   logic        rst, start;
   logic        dut_out;
   logic [3:0]  abcd;
   logic        busy, done, pass, ffv;
   logic [4:0]  err_count;
   logic [3:0]  first_fail;
`ifdef SWEEP_LOG_EN
   logic [15:0] observed;
`endif
   int          mode;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   logic_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED(16'h8000)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .dut_out_i(dut_out),
      .abcd_o(abcd), .busy_o(busy), .done_o(done), .pass_o(pass),
      .err_count_o(err_count), .first_fail_o(first_fail), .first_fail_vld_o(ffv)
`ifdef SWEEP_LOG_EN
      , .observed_o(observed)
`endif
   );

   // Function-block model: 0 AND4, 1 stuck-0, 2 NAND4, 3 stuck-1, 4 out=A, 5 out=D
   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0: dut_out = &abcd;
         1: dut_out = 1'b0;
         2: dut_out = ~(&abcd);
         3: dut_out = 1'b1;
         4: dut_out = abcd[3];
         5: dut_out = abcd[0];
         default: dut_out = 1'b0;
      endcase
   end

   typedef struct {
      int          mode;
      int          err;
      int          pass;
      int          ff;
      int          ffv;
      logic [15:0] obs;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Pulse start, follow the sweep until done; repulse_at>0 re-asserts start mid-sweep.
   task automatic do_sweep(input string tag, input int repulse_at);
      int lat;
      int abcd_bad;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk({tag, "_busy_after_start"}, busy, 1);
      chk({tag, "_done_cleared"}, done, 0);
`ifdef SWEEP_LOG_EN
      chk({tag, "_obs_cleared"}, observed, 0);
`endif
      lat = -1;
      abcd_bad = 0;
      for (int k = 1; k <= 200; k++) begin
         start = (repulse_at > 0 && k == repulse_at);
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (int'(abcd) != (k - 1) / P) abcd_bad++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, lat, 16 * P);
      chk({tag, "_abcd_sequence_errs"}, abcd_bad, 0);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_abcd_at_done"}, abcd, 0);
   endtask

   initial begin
      int seen;
      tbl[0] = '{0,  0, 1, 0, 0, 16'h8000};
      tbl[1] = '{1,  1, 0, 15, 1, 16'h0000};
      tbl[2] = '{2, 16, 0, 0, 1, 16'h7FFF};
      tbl[3] = '{3, 15, 0, 0, 1, 16'hFFFF};
      tbl[4] = '{4,  7, 0, 8, 1, 16'hFF00};
      tbl[5] = '{5,  7, 0, 1, 1, 16'hAAAA};

      mode = 0; start = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_abcd", abcd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_ffv", ffv, 0);

      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("m%0d", tbl[i].mode);
         mode = tbl[i].mode;
         do_sweep(tag, 0);
         chk({tag, "_err"}, err_count, tbl[i].err);
         chk({tag, "_pass"}, pass, tbl[i].pass);
         chk({tag, "_ffv"}, ffv, tbl[i].ffv);
         if (tbl[i].ffv != 0) chk({tag, "_first_fail"}, first_fail, tbl[i].ff);
`ifdef SWEEP_LOG_EN
         chk({tag, "_observed"}, observed, tbl[i].obs);
`endif
      end

      // Results hold in idle.
      repeat (5) @(negedge clk);
      chk("idle_hold_done", done, 1);
      chk("idle_hold_err", err_count, 7);
      chk("idle_hold_ff", first_fail, 1);

      // Start re-pulsed mid-sweep is ignored.
      mode = 1;
      do_sweep("repulse", 20);
      chk("repulse_err", err_count, 1);
      chk("repulse_ff", first_fail, 15);

      // Reset mid-sweep abandons it.
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("midrst_abcd", abcd, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_pass", pass, 0);
      chk("midrst_err", err_count, 0);
      chk("midrst_ffv", ffv, 0);
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      chk("midrst_no_activity", seen, 0);

      do_sweep("post_rst", 0);
      chk("post_rst_pass", pass, 1);
      chk("post_rst_err", err_count, 0);

`ifdef SWEEP_LOG_EN
      mode = 3;
      do_sweep("log1", 0);
      chk("log1_observed", observed, 16'hFFFF);
      chk("log1_err", err_count, 15);
      chk("log1_ff", first_fail, 0);
      do_sweep("log2", 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
